// File: rtl/sync_vg_timing.sv
// ---------------------------------------------------------------------------
// sync_vg_timing
//
// Programmable raster timing generator for the test-pattern stage. It walks
// a pixel position (x, y) across the frame and produces registered,
// zero-skew hs / vs / de strobes together with the applied active width and
// height. New timing is written into a staging set with cfg_load and is only
// moved into the applied set at a frame boundary, or immediately while the
// generator is disabled. The downstream therefore never sees a torn frame.
//
// Optional feature (compile-time macro SYNC_VG_FRAME_CNT_EN):
//   defined     -> adds output frame_cnt[15:0], a wrapping count of enabled
//                  frame boundaries, cleared whenever a new timing set is
//                  applied.
//   not defined -> no frame_cnt port and no counter logic.
//
// Ports:
//   clk_in                  in   pixel clock
//   reset_n                 in   asynchronous active-low reset
//   enable                  in   run counters; low holds the generator idle
//   cfg_h_active/fp/sync/total  in  X_BITS  staged horizontal timing
//   cfg_v_active/fp/sync/total  in  Y_BITS  staged vertical timing
//   cfg_load                in   one-cycle strobe capturing all cfg_* inputs
//   cfg_pending             out  staging loaded, not yet applied
//   cfg_err                 out  last staged set rejected (sticky to next load)
//   x / y                   out  current horizontal / vertical position
//   hs / vs / de            out  active-high syncs and data enable
//   width / height          out  applied active width / height
//   frame_cnt               out  frame counter (only with the macro above)
// ---------------------------------------------------------------------------
module sync_vg_timing #(
  parameter int X_BITS   = 13,
  parameter int Y_BITS   = 13,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_TOTAL  = 525
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [X_BITS-1:0] cfg_h_active,
  input  logic [X_BITS-1:0] cfg_h_fp,
  input  logic [X_BITS-1:0] cfg_h_sync,
  input  logic [X_BITS-1:0] cfg_h_total,
  input  logic [Y_BITS-1:0] cfg_v_active,
  input  logic [Y_BITS-1:0] cfg_v_fp,
  input  logic [Y_BITS-1:0] cfg_v_sync,
  input  logic [Y_BITS-1:0] cfg_v_total,
  input  logic              cfg_load,
  output logic              cfg_pending,
  output logic              cfg_err,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [X_BITS-1:0] width,
  output logic [Y_BITS-1:0] height
`ifdef SYNC_VG_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  // Two guard bits: the sum of three timing fields plus one can exceed a
  // single extra bit of headroom, so all window/validity math runs wider.
  localparam int XW = X_BITS + 2;
  localparam int YW = Y_BITS + 2;

  typedef struct packed {
    logic [X_BITS-1:0] hActive;
    logic [X_BITS-1:0] hFp;
    logic [X_BITS-1:0] hSync;
    logic [X_BITS-1:0] hTotal;
    logic [Y_BITS-1:0] vActive;
    logic [Y_BITS-1:0] vFp;
    logic [Y_BITS-1:0] vSync;
    logic [Y_BITS-1:0] vTotal;
  } timing_t;

  localparam timing_t DEFAULT_TIMING = '{
    hActive: X_BITS'(H_ACTIVE),
    hFp:     X_BITS'(H_FP),
    hSync:   X_BITS'(H_SYNC),
    hTotal:  X_BITS'(H_TOTAL),
    vActive: Y_BITS'(V_ACTIVE),
    vFp:     Y_BITS'(V_FP),
    vSync:   Y_BITS'(V_SYNC),
    vTotal:  Y_BITS'(V_TOTAL)
  };

  // A set is usable when both active regions and sync pulses are non-empty
  // and each total leaves room for at least one back-porch slot.
  function automatic logic timingValid(input timing_t t);
    logic [XW-1:0] hNeed;
    logic [YW-1:0] vNeed;
    hNeed = XW'(t.hActive) + XW'(t.hFp) + XW'(t.hSync) + XW'(1);
    vNeed = YW'(t.vActive) + YW'(t.vFp) + YW'(t.vSync) + YW'(1);
    timingValid = (t.hActive != '0) && (t.hSync != '0) &&
                  (XW'(t.hTotal) >= hNeed) &&
                  (t.vActive != '0) && (t.vSync != '0) &&
                  (YW'(t.vTotal) >= vNeed);
  endfunction

  timing_t appliedQ, appliedD;
  timing_t stagingQ, stagingD;
  timing_t cfgIn;

  logic pendingQ, pendingD;
  logic errQ, errD;
  logic runningQ, runningD;

  logic [X_BITS-1:0] xQ, xD;
  logic [Y_BITS-1:0] yQ, yD;
  logic hsQ, hsD;
  logic vsQ, vsD;
  logic deQ, deD;

  logic boundary;
  logic applyNow;
  logic newTiming;

  logic [XW-1:0] hSyncStart, hSyncEnd;
  logic [YW-1:0] vSyncStart, vSyncEnd;

  assign cfgIn = '{
    hActive: cfg_h_active,
    hFp:     cfg_h_fp,
    hSync:   cfg_h_sync,
    hTotal:  cfg_h_total,
    vActive: cfg_v_active,
    vFp:     cfg_v_fp,
    vSync:   cfg_v_sync,
    vTotal:  cfg_v_total
  };

  // Staging / apply control. The boundary is the last pixel of a running
  // frame; while disabled there is no frame to tear, so a pending set is
  // taken on the next edge. The apply always consumes the staging content
  // present before this edge, so a load on the boundary cycle is applied
  // one frame later and keeps cfg_pending set. A load clears cfg_err last,
  // since the error flag describes the most recently staged set.
  always_comb begin
    appliedD  = appliedQ;
    stagingD  = stagingQ;
    pendingD  = pendingQ;
    errD      = errQ;
    newTiming = 1'b0;

    boundary = runningQ && enable &&
               (xQ == appliedQ.hTotal - X_BITS'(1)) &&
               (yQ == appliedQ.vTotal - Y_BITS'(1));
    applyNow = pendingQ && (!enable || boundary);

    if (applyNow) begin
      pendingD = 1'b0;
      if (timingValid(stagingQ)) begin
        appliedD  = stagingQ;
        newTiming = 1'b1;
      end else begin
        errD = 1'b1;
      end
    end

    if (cfg_load) begin
      stagingD = cfgIn;
      pendingD = 1'b1;
      errD     = 1'b0;
    end
  end

  // Raster counters and strobes. runningQ distinguishes the first enabled
  // edge (which presents pixel 0,0) from ordinary counting edges. The
  // strobes are decoded from the next position using the timing that will
  // be in force, so they stay aligned with x/y even on the edge where a new
  // timing set takes over.
  always_comb begin
    xD       = '0;
    yD       = '0;
    runningD = 1'b0;
    hsD      = 1'b0;
    vsD      = 1'b0;
    deD      = 1'b0;

    hSyncStart = XW'(appliedD.hActive) + XW'(appliedD.hFp);
    hSyncEnd   = hSyncStart + XW'(appliedD.hSync);
    vSyncStart = YW'(appliedD.vActive) + YW'(appliedD.vFp);
    vSyncEnd   = vSyncStart + YW'(appliedD.vSync);

    if (enable) begin
      runningD = 1'b1;
      if (runningQ) begin
        if (xQ == appliedQ.hTotal - X_BITS'(1)) begin
          xD = '0;
          if (yQ == appliedQ.vTotal - Y_BITS'(1)) begin
            yD = '0;
          end else begin
            yD = yQ + Y_BITS'(1);
          end
        end else begin
          xD = xQ + X_BITS'(1);
          yD = yQ;
        end
      end
      deD = (xD < appliedD.hActive) && (yD < appliedD.vActive);
      hsD = (XW'(xD) >= hSyncStart) && (XW'(xD) < hSyncEnd);
      vsD = (YW'(yD) >= vSyncStart) && (YW'(yD) < vSyncEnd);
    end
  end

  // State register: every flop returns to its default on reset, which also
  // discards any pending staging content.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      appliedQ <= DEFAULT_TIMING;
      stagingQ <= DEFAULT_TIMING;
      pendingQ <= 1'b0;
      errQ     <= 1'b0;
      runningQ <= 1'b0;
      xQ       <= '0;
      yQ       <= '0;
      hsQ      <= 1'b0;
      vsQ      <= 1'b0;
      deQ      <= 1'b0;
    end else begin
      appliedQ <= appliedD;
      stagingQ <= stagingD;
      pendingQ <= pendingD;
      errQ     <= errD;
      runningQ <= runningD;
      xQ       <= xD;
      yQ       <= yD;
      hsQ      <= hsD;
      vsQ      <= vsD;
      deQ      <= deD;
    end
  end

`ifdef SYNC_VG_FRAME_CNT_EN
  logic [15:0] frameCntQ, frameCntD;

  // Counts completed enabled frames; a newly applied set restarts the count
  // because frames of the old timing are no longer comparable.
  always_comb begin
    frameCntD = frameCntQ;
    if (boundary) begin
      frameCntD = frameCntQ + 16'd1;
    end
    if (newTiming) begin
      frameCntD = '0;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      frameCntQ <= '0;
    end else begin
      frameCntQ <= frameCntD;
    end
  end

  assign frame_cnt = frameCntQ;
`else
  // Without the frame counter the apply flag has no consumer.
  logic unusedNewTiming;
  assign unusedNewTiming = newTiming;
`endif

  assign cfg_pending = pendingQ;
  assign cfg_err     = errQ;
  assign x           = xQ;
  assign y           = yQ;
  assign hs          = hsQ;
  assign vs          = vsQ;
  assign de          = deQ;
  assign width       = appliedQ.hActive;
  assign height      = appliedQ.vActive;

endmodule
